// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction-memory and IF/ID bundle
//
// Purpose: groups every fetch_stage signal except clk/rst so the stage and
// its environment connect through a single port.
//
// Signals:
//   stall              hold PC and IF/ID contents
//   redirect_valid     taken branch/jump resolved this cycle
//   redirect_pc        byte target of the redirect
//   imem_addr          byte address presented to instruction memory
//   imem_instruction   word returned combinationally by instruction memory
//   if_id_instruction  registered instruction
//   if_id_pc_plus4     registered PC+4 of that instruction
//   if_id_valid        IF/ID holds a real instruction (0 = bubble)
//   fault              sticky fetch fault
//   fault_pc           PC that caused the fault
//   fetch_count        instructions latched into IF/ID
//
// Modports:
//   master  the fetch stage itself
//   slave   the surrounding pipeline / instruction memory

interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  imem_instruction,
    output imem_addr,
    output if_id_instruction,
    output if_id_pc_plus4,
    output if_id_valid,
    output fault,
    output fault_pc,
    output fetch_count
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_pc,
    output imem_instruction,
    input  imem_addr,
    input  if_id_instruction,
    input  if_id_pc_plus4,
    input  if_id_valid,
    input  fault,
    input  fault_pc,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with PC, IF/ID register and fault halt
//
// Purpose: owns the program counter, presents it to a combinational
// instruction memory, captures the returned word into the IF/ID register,
// and handles stalls, redirects and illegal fetch addresses.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rst   synchronous, active-high reset
//   bus   fetch_stage_if.master (stall/redirect in, imem address out,
//         imem word in, IF/ID register, fault status and fetch counter out)
//
// Sequencing: BOOT (one cycle after reset) -> RUN -> FAULT (absorbing
// until rst).

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0040_4000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] pc_q,          pc_d;
  logic [31:0] instr_q,       instr_d;
  logic [31:0] pc_plus4_q,    pc_plus4_d;
  logic        valid_q,       valid_d;
  logic        fault_q,       fault_d;
  logic [31:0] fault_pc_q,    fault_pc_d;
  logic [31:0] count_q,       count_d;

  logic [31:0] pc_inc;
  logic        pc_aligned;
  logic        pc_in_range;
  logic        pc_legal;

  // PC+4 wraps modulo 2^32; a wrapped PC lands below IMEM_BASE and is
  // caught by the range check on the next fetch attempt.
  assign pc_inc      = pc_q + 32'd4;
  assign pc_aligned  = (pc_q[1:0] == 2'b00);
  assign pc_in_range = (pc_q >= IMEM_BASE) && (pc_q <= IMEM_LIMIT);
  assign pc_legal    = pc_aligned && pc_in_range;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // Next-state and datapath updates. Everything holds by default; each
  // state only overrides what it changes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    case (state_q)
      ST_BOOT: begin
        // PC is already on imem_addr; nothing is latched this cycle and
        // stall/redirect are not yet honoured.
        valid_d = 1'b0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (bus.redirect_valid) begin
          // Redirect beats stall: the wrong-path word is squashed and the
          // target is only checked when it is actually fetched.
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          // Hold everything.
          pc_d = pc_q;
        end else if (!pc_legal) begin
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
        end else begin
          instr_d    = bus.imem_instruction;
          pc_plus4_d = pc_inc;
          valid_d    = 1'b1;
          pc_d       = pc_inc;
          count_d    = count_q + 32'd1;
        end
      end

      ST_FAULT: begin
        // Absorbing: only rst leaves this state.
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // imem_addr is the bare PC register so there is no input-to-address path.
  assign bus.imem_addr         = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc_plus4    = pc_plus4_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.fault             = fault_q;
  assign bus.fault_pc          = fault_pc_q;
  assign bus.fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two fixed boot words, otherwise 0xAC00_xxxx where
  // xxxx is the low half of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0040_0000) return 32'h2008_0005;
    if (addr == 32'h0040_0004) return 32'h2009_0007;
    return {16'hAC00, addr[15:0]};
  endfunction

  assign bus.imem_instruction = mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".addr"},   bus.imem_addr,         32'h0040_0000);
    check({tag, ".instr"},  bus.if_id_instruction, 32'd0);
    check({tag, ".pc4"},    bus.if_id_pc_plus4,    32'd0);
    check({tag, ".valid"},  {31'd0, bus.if_id_valid}, 32'd0);
    check({tag, ".fault"},  {31'd0, bus.fault},    32'd0);
    check({tag, ".fpc"},    bus.fault_pc,          32'd0);
    check({tag, ".count"},  bus.fetch_count,       32'd0);
  endtask

  // Release reset and verify the two-edge boot latency; redirect is held
  // high during BOOT to show it is ignored there.
  task automatic boot_sequence(input string tag);
    rst = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0200;
    tick();
    check({tag, ".e1.valid"}, {31'd0, bus.if_id_valid}, 32'd0);
    check({tag, ".e1.addr"},  bus.imem_addr, 32'h0040_0000);
    bus.redirect_valid = 1'b0;
    tick();
    check({tag, ".e2.instr"}, bus.if_id_instruction, 32'h2008_0005);
    check({tag, ".e2.pc4"},   bus.if_id_pc_plus4,    32'h0040_0004);
    check({tag, ".e2.valid"}, {31'd0, bus.if_id_valid}, 32'd1);
    check({tag, ".e2.count"}, bus.fetch_count, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    tick();
    tick();
    check_reset_values("rst");

    boot_sequence("boot");

    // Stall three edges after the first valid fetch.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.instr", bus.if_id_instruction, 32'h2008_0005);
      check("stall.addr",  bus.imem_addr,         32'h0040_0004);
      check("stall.count", bus.fetch_count,       32'd1);
      check("stall.valid", {31'd0, bus.if_id_valid}, 32'd1);
    end
    bus.stall = 1'b0;
    tick();
    check("resume.instr", bus.if_id_instruction, 32'h2009_0007);
    check("resume.pc4",   bus.if_id_pc_plus4,    32'h0040_0008);
    check("resume.count", bus.fetch_count,       32'd2);

    // Redirect together with stall: redirect wins.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0100;
    bus.stall = 1'b1;
    tick();
    check("redir.addr",  bus.imem_addr, 32'h0040_0100);
    check("redir.valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("redir.count", bus.fetch_count, 32'd2);
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    tick();
    check("target.instr", bus.if_id_instruction, 32'hAC00_0100);
    check("target.pc4",   bus.if_id_pc_plus4,    32'h0040_0104);
    check("target.valid", {31'd0, bus.if_id_valid}, 32'd1);
    check("target.count", bus.fetch_count, 32'd3);

    // Upper boundary: 0x0040_4000 fetches, 0x0040_4004 faults.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_4000;
    tick();
    bus.redirect_valid = 1'b0;
    check("lim.addr", bus.imem_addr, 32'h0040_4000);
    tick();
    check("lim.instr", bus.if_id_instruction, 32'hAC00_4000);
    check("lim.pc4",   bus.if_id_pc_plus4,    32'h0040_4004);
    check("lim.count", bus.fetch_count,       32'd4);
    // Stalling on an illegal PC must not fault.
    bus.stall = 1'b1;
    tick();
    check("lim.stall.fault", {31'd0, bus.fault}, 32'd0);
    bus.stall = 1'b0;
    tick();
    check("over.fault", {31'd0, bus.fault}, 32'd1);
    check("over.fpc",   bus.fault_pc, 32'h0040_4004);
    check("over.valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("over.addr",  bus.imem_addr, 32'h0040_4004);
    check("over.count", bus.fetch_count, 32'd4);

    // FAULT ignores a legal redirect.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0000;
    tick();
    check("flt.fault", {31'd0, bus.fault}, 32'd1);
    check("flt.addr",  bus.imem_addr, 32'h0040_4004);
    bus.redirect_valid = 1'b0;

    // Reset out of FAULT.
    rst = 1'b1;
    tick();
    check_reset_values("rst_flt");
    boot_sequence("reboot");

    // Misaligned redirect target.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0102;
    tick();
    bus.redirect_valid = 1'b0;
    check("mis.addr",  bus.imem_addr, 32'h0040_0102);
    check("mis.fault0", {31'd0, bus.fault}, 32'd0);
    tick();
    check("mis.fault", {31'd0, bus.fault}, 32'd1);
    check("mis.fpc",   bus.fault_pc, 32'h0040_0102);
    check("mis.valid", {31'd0, bus.if_id_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0000;
    tick();
    tick();
    bus.redirect_valid = 1'b0;
    check("mis.stuck.fault", {31'd0, bus.fault}, 32'd1);
    check("mis.stuck.addr",  bus.imem_addr, 32'h0040_0102);
    check("mis.stuck.fpc",   bus.fault_pc, 32'h0040_0102);

    // Reset, then lower boundary: one word below IMEM_BASE faults.
    rst = 1'b1;
    tick();
    check_reset_values("rst_mis");
    boot_sequence("boot3");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h003F_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("low.fault", {31'd0, bus.fault}, 32'd1);
    check("low.fpc",   bus.fault_pc, 32'h003F_FFFC);
    check("low.count", bus.fetch_count, 32'd1);

    // Reset mid-run with redirect and stall active: reset wins.
    rst = 1'b1;
    tick();
    boot_sequence("boot4");
    tick();
    check("run.count", bus.fetch_count, 32'd2);
    rst = 1'b1;
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0300;
    tick();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    check_reset_values("rst_run");
    boot_sequence("boot5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
